// File: rtl/seq_detect_1011.sv
// seq_detect_1011: Moore detector for the serial pattern 1-0-1-1 with a
// saturating hit counter.
// Build option: define SEQ_DETECT_OVERLAP_EN for overlapping detection
// (S4 on a 0 resumes at S2); left undefined, S4 on a 0 restarts at S0.
module seq_detect_1011 #(
  parameter int unsigned COUNT_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               in_valid,
  input  logic               din,
  output logic               detect,
  output logic [2:0]         state,
  output logic [COUNT_W-1:0] hit_count
);

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_t;

  localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

  state_t state_q;
  state_t state_d;
  logic   hit_c;

  // State register: three flops, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; illegal codes recover to S0 even without a valid bit.
  always_comb begin
    state_d = state_q;
    hit_c   = 1'b0;
    if (clear) begin
      state_d = S0;
    end else begin
      unique case (state_q)
        S0: if (in_valid) state_d = din ? S1 : S0;
        S1: if (in_valid) state_d = din ? S1 : S2;
        S2: if (in_valid) state_d = din ? S3 : S0;
        S3: if (in_valid) state_d = din ? S4 : S2;
`ifdef SEQ_DETECT_OVERLAP_EN
        S4: if (in_valid) state_d = din ? S1 : S2;
`else
        S4: if (in_valid) state_d = din ? S1 : S0;
`endif
        default: state_d = S0;
      endcase
      hit_c = (state_d == S4) && (state_q != S4);
    end
  end

  // Registered Moore flag, loaded with the decode of the next state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      detect <= 1'b0;
    end else begin
      detect <= (state_d == S4);
    end
  end

  // Saturating hit counter; clear wins over a concurrent match.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count <= '0;
    end else if (clear) begin
      hit_count <= '0;
    end else if (hit_c && (hit_count != COUNT_MAX)) begin
      hit_count <= hit_count + COUNT_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_seq_detect_1011.sv
// Scoreboarded bench for seq_detect_1011: a pattern-matching reference model
// predicts each cycle's outputs, a monitor compares after every rising edge.
module tb_seq_detect_1011;

  localparam int unsigned COUNT_W = 3;
  localparam int unsigned CNT_MAX = (1 << COUNT_W) - 1;

  typedef struct {
    logic [2:0]         st;
    logic               det;
    logic [COUNT_W-1:0] cnt;
  } exp_t;

  logic               clk;
  logic               reset;
  logic               clear;
  logic               in_valid;
  logic               din;
  logic               detect;
  logic [2:0]         state;
  logic [COUNT_W-1:0] hit_count;

  int checks = 0;
  int errors = 0;
  int pushes = 0;
  int pops   = 0;

  exp_t sb_q[$];

  // Reference model state: recent valid bits since reset/clear/last match
  bit          hist[$];
  int          m_cnt = 0;
  bit          m_det = 1'b0;
  int          m_st  = 0;
  bit          pat[4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  seq_detect_1011 #(.COUNT_W(COUNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .din       (din),
    .detect    (detect),
    .state     (state),
    .hit_count (hit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Longest proper progress toward the pattern held by the tail of h.
  function automatic int prefix_len(input bit h[$]);
    for (int k = 3; k >= 1; k--) begin
      if (h.size() >= k) begin
        bit ok = 1'b1;
        for (int i = 0; i < k; i++)
          if (h[h.size() - k + i] != pat[i]) ok = 1'b0;
        if (ok) return k;
      end
    end
    return 0;
  endfunction

  function automatic bit tail_match(input bit h[$]);
    if (h.size() < 4) return 1'b0;
    for (int i = 0; i < 4; i++)
      if (h[h.size() - 4 + i] != pat[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  // Apply one cycle of stimulus at the falling edge and predict its result.
  task automatic drive(input bit r, input bit c, input bit v, input bit d);
    exp_t e;
    @(negedge clk);
    reset    = r;
    clear    = c;
    in_valid = v;
    din      = d;
    if (!r || c) begin
      hist.delete();
      m_cnt = 0;
      m_det = 1'b0;
      m_st  = 0;
    end else if (v) begin
      hist.push_back(d);
      if (hist.size() > 4) void'(hist.pop_front());
      if (tail_match(hist)) begin
        m_det = 1'b1;
        m_st  = 4;
        if (m_cnt < CNT_MAX) m_cnt++;
`ifndef SEQ_DETECT_OVERLAP_EN
        hist.delete();
`endif
      end else begin
        m_det = 1'b0;
        m_st  = prefix_len(hist);
      end
    end
    e.st  = 3'(m_st);
    e.det = m_det;
    e.cnt = COUNT_W'(m_cnt);
    sb_q.push_back(e);
    pushes++;
  endtask

  task automatic drive_bits(input bit b[$]);
    foreach (b[i]) drive(1'b1, 1'b0, 1'b1, b[i]);
  endtask

  // Monitor: compare DUT outputs against the predicted values after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        pops++;
        check("state", int'(state), int'(e.st));
        check("detect", int'(detect), int'(e.det));
        check("hit_count", int'(hit_count), int'(e.cnt));
      end
    end
  end

  initial begin
    bit seq[$];
    int wait_cyc;
    reset    = 1'b0;
    clear    = 1'b0;
    in_valid = 1'b0;
    din      = 1'b0;

    // Held in reset with live traffic
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b1, 1'(i & 1));
    seq = '{1, 0, 1, 1};
    drive_bits(seq);
    drive(1'b1, 1'b0, 1'b0, 1'b0);

    // Overlap stream 1011011
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    seq = '{1, 0, 1, 1, 0, 1, 1};
    drive_bits(seq);
    @(posedge clk); #2;
`ifdef SEQ_DETECT_OVERLAP_EN
    check("overlap_hits", int'(hit_count), 2);
`else
    check("overlap_hits", int'(hit_count), 1);
`endif

    // Bubbles between pattern bits
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #2;
    check("bubble_detect", int'(detect), 1);
    check("bubble_hits", int'(hit_count), 1);

    // Near miss, one hit at the end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    seq = '{1, 0, 0, 1, 1, 1, 0, 1, 1};
    drive_bits(seq);

    // Saturation: repeated non-overlapping patterns
    for (int p = 0; p < 10; p++) begin
      seq = '{1, 0, 1, 1};
      drive_bits(seq);
    end
    @(posedge clk); #2;
    check("saturated", int'(hit_count), int'(CNT_MAX));

    // Clear on the final pattern bit
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    seq = '{1, 0, 1};
    drive_bits(seq);
    drive(1'b1, 1'b1, 1'b1, 1'b1);

    // Asynchronous reset while sitting in S3
    seq = '{1, 0, 1};
    drive_bits(seq);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("async_state", int'(state), 0);
    check("async_detect", int'(detect), 0);
    check("async_hits", int'(hit_count), 0);
    drive(1'b0, 1'b0, 1'b1, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bit r, c, v, d;
      r = ($urandom_range(0, 99) >= 2);
      c = ($urandom_range(0, 99) < 2);
      v = ($urandom_range(0, 99) < 75);
      d = 1'($urandom);
      drive(r, c, v, d);
    end

    // Drain the scoreboard with a bounded wait
    wait_cyc = 0;
    while (sb_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      #2;
      wait_cyc++;
    end
    check("scoreboard_drained", sb_q.size(), 0);
    check("pops_vs_pushes", pops, pushes);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_detect_1011.md
# seq_detect_1011

Moore sequence detector for the serial bit pattern 1-0-1-1, with a saturating match counter. Its state register is a bank of three single-bit flip-flops clocked on the rising edge; this block contains the next-state logic that feeds that register and the output logic that decodes the registered state. It consumes a qualified serial bit stream and presents a registered match flag plus a running hit count to downstream logic.

## Interface
- `COUNT_W`, default 8: width of the match counter; it saturates at 2^COUNT_W−1.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low. Low forces all state and outputs to reset values immediately.
- `clear` input 1: synchronous clear. Returns the FSM to S0 and zeroes `hit_count`. Has priority over `in_valid`.
- `in_valid` input 1: `din` is sampled only when this is high on a rising edge.
- `din` input 1: serial data bit.
- `detect` output 1: high while state is S4 (Moore output, registered).
- `state` output 3: current state encoding, for observation.
- `hit_count` output COUNT_W: number of matches since reset or clear, saturating.

## Operation
- State encoding: S0=000 (idle), S1=001 (seen "1"), S2=010 (seen "10"), S3=011 (seen "101"), S4=100 (seen "1011", match). Codes 101–111 are illegal and go to S0 on the next edge regardless of `in_valid`.
- Transitions are taken only on an edge with `in_valid`=1. The `din`=0 / `din`=1 targets are:
  - S0: 0 → S0; 1 → S1.
  - S1: 0 → S2; 1 → S1.
  - S2: 0 → S0; 1 → S3.
  - S3: 0 → S2; 1 → S4.
  - S4: depends on configuration (see below).
- When `in_valid`=0, the state holds. This includes S4, so `detect` stays high until the next valid bit.
- `hit_count` increments by 1 on every edge where the next state is S4 and the current state is not S4. Since S4 has no self-loop, this is every entry into S4.
- At 2^COUNT_W−1, `hit_count` holds; it does not wrap.
- `clear`=1 on an edge: state becomes S0 and `hit_count` becomes 0. Any concurrent match is discarded and does not count.
- `detect` is decoded from the state register only. It has no combinational path from `din`.

## Timing
- Reset values:
  - `state`=000.
  - `detect`=0.
  - `hit_count`=0.
- Reset deassertion is taken on any edge. The first valid bit is sampled on the first rising edge with `reset` high.
- Latency: the fourth bit of the pattern is sampled on edge N. `detect` and the incremented `hit_count` are visible after edge N, i.e. during cycle N+1.
- If `reset` is asserted mid-pattern, partial progress is lost and no count is made. The stream after reset must present the full pattern again.
- Simultaneous `clear` and final pattern bit: `clear` wins. Result is `state`=S0 and `hit_count`=0.
- Bubbles (`in_valid`=0) between pattern bits do not break a match.

## Configuration
- `SEQ_DETECT_OVERLAP_EN` defined (overlapping detection):
  - S4 with `din`=0 → S2.
  - S4 with `din`=1 → S1.
  - Suffixes of a match can begin the next match, so 1011011 yields 2 hits.
- `SEQ_DETECT_OVERLAP_EN` undefined (non-overlapping detection):
  - S4 with `din`=0 → S0.
  - S4 with `din`=1 → S1.
  - 1011011 yields 1 hit.
- All other transitions, outputs and timing are identical in both builds.

## Test plan
- Reset check: hold `reset`=0 with `din` toggling and `in_valid`=1 → `state`=000, `detect`=0, `hit_count`=0 throughout. Then release and drive 1,0,1,1 valid → `detect`=1 in the cycle after the 4th bit, `hit_count`=1.
- Overlap check: drive stream 1,0,1,1,0,1,1 with `in_valid`=1 every cycle.
  - With overlap enabled → `hit_count`=2 and `detect` pulses twice.
  - With overlap disabled → `hit_count`=1.
- Bubble check: drive 1, (`in_valid`=0 ×3), 0, 1, (`in_valid`=0 ×2), 1 → `detect`=1 after the last valid bit and stays 1 through subsequent `in_valid`=0 cycles; `hit_count`=1.
- Near-miss check: drive 1,0,0,1,1,1,0,1,1 → state path S1,S2,S0,S1,S1,S1,S2,S3,S4 → exactly 1 hit, at the final bit.
- Saturation check: with `COUNT_W`=2, drive 4 non-overlapping "1011" patterns → `hit_count` goes 1,2,3,3.
- Clear and mid-pattern reset check:
  - Assert `clear` on the edge sampling the final 1 of 1011 → `state`=S0, `hit_count`=0.
  - Assert `reset` asynchronously in S3 → `state`=000 immediately, before the next edge.
